serial_frame_tx: RTL and testbench

//   Transmit end of the 1-bit serial link that the buffer block receives on its `in` pin.

---
 rtl/serial_frame_tx_pkg.sv | 28 ++
 rtl/serial_frame_tx_bit_timer.sv | 29 ++
 rtl/serial_frame_tx.sv | 118 +++++++++++
 tb/tb_serial_frame_tx.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_frame_tx_pkg.sv
// Shared serial-link definitions: FSM state encodings, line levels and frame format.
// Imported by the transmitter and usable by the matching receive side.
package serial_frame_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_t;

    localparam logic LINE_IDLE  = 1'b1;
    localparam logic LINE_START = 1'b0;

    // Frame format: one start bit, payload LSB-first, optional even parity, one stop bit.
    localparam int FRAME_OVERHEAD_BITS = 2;

    function automatic int frame_bits(input int data_w, input bit parity_en);
        return FRAME_OVERHEAD_BITS + data_w + (parity_en ? 1 : 0);
    endfunction

    // Counter width for a count range of n values, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/serial_frame_tx_bit_timer.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and raises tick in the last clock of each period.
module bit_timer
    import serial_frame_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    output logic tick
);

    localparam int CNT_W = cnt_width(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt;

    assign tick = (cnt == CNT_LAST);

    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset || clr || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/serial_frame_tx.sv
// Framed serial transmitter: start bit, payload LSB-first, optional even parity, stop bit.
// Each bit is held CLKS_PER_BIT clocks; the registered line idles high.
module serial_frame_tx
    import serial_frame_tx_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 4,
    parameter bit PARITY_EN    = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              out,
    output logic              busy,
    output logic              done
);

    localparam int IDX_W = cnt_width(DATA_W);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

    tx_state_t         state, state_next;
    logic [DATA_W-1:0] shreg, shreg_next;
    logic [IDX_W-1:0]  idx, idx_next;
    logic              parity_q, parity_next;
    logic              out_next;
    logic              tick;
    logic              timer_clr;
    logic              accept;

    // Holding the timer clear while idle aligns every bit period to the accept edge.
    assign timer_clr = (state == ST_IDLE);

    bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .clk  (clk),
        .reset(reset),
        .clr  (timer_clr),
        .tick (tick)
    );

    assign in_ready = (state == ST_IDLE);
    assign accept   = in_valid & in_ready;
    assign busy     = (state != ST_IDLE);
    assign done     = (state == ST_STOP) & tick & ~reset;

    // NOTE: every signal driven here gets a default first; a missed path would infer a latch.
    always_comb begin
        state_next  = state;
        shreg_next  = shreg;
        idx_next    = idx;
        parity_next = parity_q;

        unique case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_next  = ST_START;
                    shreg_next  = in_data;
                    parity_next = ^in_data;
                    idx_next    = '0;
                end
            end
            ST_START: begin
                if (tick) state_next = ST_DATA;
            end
            ST_DATA: begin
                if (tick) begin
                    if (idx == LAST_IDX) begin
                        state_next = PARITY_EN ? ST_PARITY : ST_STOP;
                        idx_next   = '0;
                    end else begin
                        idx_next   = idx + 1'b1;
                        shreg_next = shreg >> 1;
                    end
                end
            end
            ST_PARITY: begin
                if (tick) state_next = ST_STOP;
            end
            ST_STOP: begin
                if (tick) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // The line level is decoded from the next state so that out is a clean register.
    always_comb begin
        out_next = LINE_IDLE;
        unique case (state_next)
            ST_IDLE:   out_next = LINE_IDLE;
            ST_START:  out_next = LINE_START;
            ST_DATA:   out_next = shreg_next[0];
            ST_PARITY: out_next = parity_next;
            ST_STOP:   out_next = LINE_IDLE;
            default:   out_next = LINE_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            shreg    <= '0;
            idx      <= '0;
            parity_q <= 1'b0;
            out      <= LINE_IDLE;
        end else begin
            state    <= state_next;
            shreg    <= shreg_next;
            idx      <= idx_next;
            parity_q <= parity_next;
            out      <= out_next;
        end
    end

endmodule

// File: tb/tb_serial_frame_tx.sv
// Scoreboard bench: drivers push expected line waveforms at accept, monitors compare whole frames.
module tb_serial_frame_tx;

    typedef struct {
        logic [63:0] bits;
        int          len;
        bit          aborted;
    } exp_t;

    logic       clk;
    logic       reset;
    logic [7:0] in_data, in_data6;
    logic       in_valid, in_valid6;
    logic       in_ready, in_ready6;
    logic       out, out6;
    logic       busy, busy6;
    logic       done, done6;

    int  total = 0;
    int  bad   = 0;
    exp_t q_a[$];
    exp_t q_b[$];
    time last_acc;
    time last_acc6;

    serial_frame_tx #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY_EN(1'b1)) dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .out(out), .busy(busy), .done(done)
    );

    serial_frame_tx #(.DATA_W(8), .CLKS_PER_BIT(1), .PARITY_EN(1'b0)) dut6 (
        .clk(clk), .reset(reset), .in_data(in_data6), .in_valid(in_valid6),
        .in_ready(in_ready6), .out(out6), .busy(busy6), .done(done6)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    // Reference waveform: list the frame symbols, then repeat each one cpb times.
    function automatic exp_t build(input logic [7:0] d, input int cpb, input bit par);
        exp_t e;
        bit   sym[$];
        int   n = 0;
        sym.push_back(1'b0);
        for (int i = 0; i < 8; i++) sym.push_back(d[i]);
        if (par) begin
            int ones = 0;
            for (int i = 0; i < 8; i++) ones += int'(d[i]);
            sym.push_back(ones % 2 == 1);
        end
        sym.push_back(1'b1);
        e.bits = '0;
        foreach (sym[k]) begin
            for (int c = 0; c < cpb; c++) begin
                e.bits[n] = sym[k];
                n++;
            end
        end
        e.len     = n;
        e.aborted = 1'b0;
        return e;
    endfunction

    task automatic finish_frame(input string tag, input exp_t e, input logic [63:0] cap,
                                input int cap_len, input int done_cnt, input int done_pos);
        logic [63:0] mask;
        if (e.aborted) begin
            mask = (cap_len >= 64) ? '1 : ((64'd1 << cap_len) - 64'd1);
            check({tag, "_abort_len"}, cap_len, e.len);
            check({tag, "_abort_line"}, cap & mask, e.bits & mask);
            check({tag, "_abort_done"}, done_cnt, 0);
        end else begin
            check({tag, "_busy_len"}, cap_len, e.len);
            check({tag, "_line"}, cap, e.bits);
            check({tag, "_done_count"}, done_cnt, 1);
            check({tag, "_done_clock"}, done_pos, e.len);
        end
    endtask

    logic [63:0] cap_a, cap_b;
    int  len_a, len_b, dcnt_a, dcnt_b, dpos_a, dpos_b;
    bit  prev_a = 1'b0;
    bit  prev_b = 1'b0;

    always @(negedge clk) begin
        if (busy === 1'b1) begin
            if (!prev_a) begin
                cap_a = '0; len_a = 0; dcnt_a = 0; dpos_a = 0;
            end
            if (len_a < 64) cap_a[len_a] = out;
            len_a++;
            if (done === 1'b1) begin
                dcnt_a++;
                dpos_a = len_a;
            end
        end else begin
            if (done === 1'b1) check("a_done_while_idle", done, 1'b0);
            if (prev_a) begin
                if (q_a.size() == 0) begin
                    total++; bad++;
                    $display("FAIL a_unexpected_frame: got frame of %0d clocks want none", len_a);
                end else begin
                    finish_frame("a", q_a.pop_front(), cap_a, len_a, dcnt_a, dpos_a);
                end
            end
        end
        prev_a = (busy === 1'b1);
    end

    always @(negedge clk) begin
        if (busy6 === 1'b1) begin
            if (!prev_b) begin
                cap_b = '0; len_b = 0; dcnt_b = 0; dpos_b = 0;
            end
            if (len_b < 64) cap_b[len_b] = out6;
            len_b++;
            if (done6 === 1'b1) begin
                dcnt_b++;
                dpos_b = len_b;
            end
        end else begin
            if (done6 === 1'b1) check("b_done_while_idle", done6, 1'b0);
            if (prev_b) begin
                if (q_b.size() == 0) begin
                    total++; bad++;
                    $display("FAIL b_unexpected_frame: got frame of %0d clocks want none", len_b);
                end else begin
                    finish_frame("b", q_b.pop_front(), cap_b, len_b, dcnt_b, dpos_b);
                end
            end
        end
        prev_b = (busy6 === 1'b1);
    end

    task automatic send(input logic [7:0] d, input bit hold);
        bit ok = 1'b0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (in_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        check("a_ready_wait", ok, 1'b1);
        in_data  = d;
        in_valid = 1'b1;
        q_a.push_back(build(d, 4, 1'b1));
        last_acc = $time;
        @(posedge clk);
        #1;
        if (!hold) in_valid = 1'b0;
        in_data = 8'($urandom);
    endtask

    task automatic send6(input logic [7:0] d, input bit hold);
        bit ok = 1'b0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (in_ready6 === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        check("b_ready_wait", ok, 1'b1);
        in_data6  = d;
        in_valid6 = 1'b1;
        q_b.push_back(build(d, 1, 1'b0));
        last_acc6 = $time;
        @(posedge clk);
        #1;
        if (!hold) in_valid6 = 1'b0;
        in_data6 = 8'($urandom);
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no finish want finish");
        $fatal(1, "time limit");
    end

    initial begin
        time  t1;
        int   hits;
        bit   seen_done;
        exp_t e;

        reset = 1'b1;
        in_data = '0; in_valid = 1'b0;
        in_data6 = '0; in_valid6 = 1'b0;

        // T1: reset held three cycles
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_out", out, 1'b1);
            check("rst_busy", busy, 1'b0);
            check("rst_done", done, 1'b0);
            check("rst_out6", out6, 1'b1);
        end
        reset = 1'b0;
        @(negedge clk);
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_in_ready6", in_ready6, 1'b1);

        // T2: single frame
        send(8'hA5, 1'b0);

        // T3: back-to-back with in_valid held
        send(8'hFF, 1'b1);
        t1 = last_acc;
        send(8'h01, 1'b0);
        check("b2b_accept_spacing", 64'((last_acc - t1) / 10), 64'd45);

        // T4: in_valid held with new data while busy
        send(8'h5A, 1'b1);
        in_data   = 8'h00;
        hits      = 0;
        seen_done = 1'b0;
        for (int n = 0; n < 100 && !seen_done; n++) begin
            @(negedge clk);
            if (busy === 1'b1 && in_ready === 1'b1) hits++;
            if (done === 1'b1) begin
                seen_done = 1'b1;
                in_valid  = 1'b0;
            end
        end
        check("busy_ready_low", hits, 0);
        check("busy_done_seen", seen_done, 1'b1);
        @(negedge clk);
        @(negedge clk);
        check("busy_no_reaccept", busy, 1'b0);

        // T5: reset during data bit 3 (clock 18 after accept)
        send(8'hC3, 1'b0);
        repeat (18) @(negedge clk);
        e = q_a.pop_back();
        e.aborted = 1'b1;
        e.len     = 18;
        q_a.push_back(e);
        reset = 1'b1;
        @(negedge clk);
        check("midrst_out", out, 1'b1);
        check("midrst_busy", busy, 1'b0);
        check("midrst_done", done, 1'b0);
        reset = 1'b0;
        send(8'h3C, 1'b0);

        // T6: no parity, one clock per bit
        send6(8'h01, 1'b0);

        // Randomised traffic on both instances
        for (int i = 0; i < 12; i++) begin
            send(8'($urandom), 1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        send(8'($urandom), 1'b0);
        for (int i = 0; i < 12; i++) begin
            send6(8'($urandom), 1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        send6(8'($urandom), 1'b0);

        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if (q_a.size() == 0 && q_b.size() == 0 && busy === 1'b0 && busy6 === 1'b0) break;
        end
        check("drain_a", q_a.size(), 0);
        check("drain_b", q_b.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
